// File: rtl/dilithium_pkg.sv
// Shared Dilithium definitions for the byte assembler and the Decompose stage.
//   Q       : modulus 8380417
//   N       : coefficients per polynomial
//   GAMMA2  : (Q-1)/32, low-order rounding range used by Decompose
//   coeff_t : 32-bit coefficient word (the Decompose `r` input)
//   asm_state_t : control states of coeff_byte_assembler
package dilithium_pkg;

  localparam int Q      = 8380417;
  localparam int N      = 256;
  localparam int GAMMA2 = (Q - 1) / 32;

  typedef logic [31:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } asm_state_t;

  // Little-endian 23-bit candidate; bit 7 of the top byte is discarded.
  function automatic logic [22:0] rej_candidate(input logic [7:0] b2,
                                                input logic [7:0] b1,
                                                input logic [7:0] b0);
    return {b2[6:0], b1, b0};
  endfunction

endpackage

// File: rtl/coeff_byte_assembler_if.sv
// Byte-in / coefficient-out handshake bundle of coeff_byte_assembler.
//   in_byte, in_valid, in_ready : byte stream into the assembler
//   out_coeff, out_valid, out_ready : accepted coefficient towards Decompose
// Modports: slave = the assembler, master = the producer/consumer side.
interface coeff_byte_assembler_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_coeff;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_coeff, out_valid
  );

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_coeff, out_valid
  );
endinterface

// File: rtl/coeff_byte_assembler.sv
// Collects bytes three at a time, forms 23-bit little-endian candidates,
// rejects those >= Q and hands accepted ones to Decompose until N
// coefficients have been delivered.
// Ports:
//   clk       : system clock
//   rst       : asynchronous, active-low reset
//   start     : one-cycle pulse, begins a run (honoured in IDLE/DONE only)
//   bus       : byte-in / coefficient-out handshake (slave modport)
//   busy      : run in progress (COLLECT or EMIT)
//   done      : N coefficients delivered, held until the next start
//   rej_count : candidates rejected this run, saturating
module coeff_byte_assembler
  import dilithium_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int Q     = dilithium_pkg::Q,
  parameter int N     = dilithium_pkg::N,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  coeff_byte_assembler_if.slave     bus,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          rej_count
);

  localparam int              IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [23:0]     Q_BOUND  = 24'(Q);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  asm_state_t       state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       b0_q, b0_d;
  logic [7:0]       b1_q, b1_d;
  logic [IDX_W-1:0] coeff_idx_q, coeff_idx_d;
  logic [CNT_W-1:0] rej_q, rej_d;
  logic [WIDTH-1:0] coeff_q, coeff_d;

  logic [22:0]      cand;
  logic             cand_ok;

  // Third-byte cycle: candidate formed and compared combinationally,
  // result captured together with out_coeff.
  always_comb begin
    cand    = rej_candidate(bus.in_byte, b1_q, b0_q);
    cand_ok = {1'b0, cand} < Q_BOUND;

    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    coeff_idx_d = coeff_idx_q;
    rej_d       = rej_q;
    coeff_d     = coeff_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = COLLECT;
          byte_idx_d  = '0;
          coeff_idx_d = '0;
          rej_d       = '0;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          unique case (byte_idx_q)
            2'd0: begin
              b0_d       = bus.in_byte;
              byte_idx_d = 2'd1;
            end
            2'd1: begin
              b1_d       = bus.in_byte;
              byte_idx_d = 2'd2;
            end
            default: begin
              byte_idx_d = 2'd0;
              if (cand_ok) begin
                coeff_d = {{(WIDTH-23){1'b0}}, cand};
                state_d = EMIT;
              end else begin
                rej_d = sat_inc(rej_q);
              end
            end
          endcase
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (coeff_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            coeff_idx_d = coeff_idx_q + 1'b1;
            state_d     = COLLECT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: control and datapath state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      coeff_idx_q <= '0;
      rej_q       <= '0;
      coeff_q     <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      coeff_idx_q <= coeff_idx_d;
      rej_q       <= rej_d;
      coeff_q     <= coeff_d;
    end
  end

  // Outputs decoded from the state register only, so neither in_valid nor
  // out_ready reaches an output combinationally.
  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_coeff = coeff_q;
  assign busy          = (state_q == COLLECT) || (state_q == EMIT);
  assign done          = (state_q == DONE);
  assign rej_count     = rej_q;

endmodule

// File: tb/tb_coeff_byte_assembler.sv
// Directed plus randomized bench for coeff_byte_assembler (N=4, CNT_W=3).
module tb_coeff_byte_assembler;

  localparam int QV    = 8380417;
  localparam int NV    = 4;
  localparam int CW    = 3;
  localparam int SATV  = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [CW-1:0] rej_count;

  coeff_byte_assembler_if #(.WIDTH(32)) bus ();

  coeff_byte_assembler #(
    .WIDTH(32), .Q(QV), .N(NV), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .rej_count (rej_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the triple in flight, accepted count,
  // rejection count and last accepted value.
  int pend[$];
  int exp_cnt   = 0;
  int exp_rej   = 0;
  int exp_coeff = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pend.delete();
    exp_cnt = 0;
    exp_rej = 0;
    chk("start_busy", 32'(busy), 1);
    chk("start_in_ready", 32'(bus.in_ready), 1);
    chk("start_done", 32'(done), 0);
    chk("start_rej", 32'(rej_count), 0);
  endtask

  task automatic put_byte(input logic [7:0] b);
    chk("byte_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    pend.push_back(int'(b));
  endtask

  // Judge the completed triple from the model's rules, then optionally
  // stall the consumer for `hold` cycles before taking the coefficient.
  task automatic eval_triple(input int hold);
    int cand;
    cand = pend[0] + pend[1] * 256 + (pend[2] % 128) * 65536;
    pend.delete();
    if (cand < QV) begin
      exp_coeff = cand;
      chk("acc_out_valid", 32'(bus.out_valid), 1);
      chk("acc_out_coeff", bus.out_coeff, 32'(cand));
      chk("acc_in_ready", 32'(bus.in_ready), 0);
      chk("acc_busy", 32'(busy), 1);
      chk("acc_rej", 32'(rej_count), 32'(exp_rej));
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'($urandom);
        @(negedge clk);
        chk("bp_out_valid", 32'(bus.out_valid), 1);
        chk("bp_out_coeff", bus.out_coeff, 32'(cand));
        chk("bp_in_ready", 32'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_cnt++;
      chk("post_out_valid", 32'(bus.out_valid), 0);
      if (exp_cnt == NV) begin
        chk("fin_done", 32'(done), 1);
        chk("fin_busy", 32'(busy), 0);
        chk("fin_in_ready", 32'(bus.in_ready), 0);
        chk("fin_rej", 32'(rej_count), 32'(exp_rej));
      end else begin
        chk("post_in_ready", 32'(bus.in_ready), 1);
        chk("post_done", 32'(done), 0);
      end
    end else begin
      exp_rej = (exp_rej < SATV) ? exp_rej + 1 : SATV;
      chk("rej_out_valid", 32'(bus.out_valid), 0);
      chk("rej_count", 32'(rej_count), 32'(exp_rej));
      chk("rej_in_ready", 32'(bus.in_ready), 1);
    end
  endtask

  task automatic send(input int cand, input int hold);
    logic [7:0] b2;
    b2 = 8'((cand >> 16) & 127) | (8'($urandom_range(0, 1)) << 7);
    put_byte(8'(cand & 255));
    put_byte(8'((cand >> 8) & 255));
    put_byte(b2);
    eval_triple(hold);
  endtask

  function automatic int rand_acc();
    return int'($urandom_range(0, QV - 1));
  endfunction

  function automatic int rand_rej();
    return int'($urandom_range(QV, (1 << 23) - 1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    start         = 1'b0;
    bus.in_byte   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_coeff", bus.out_coeff, 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rej", 32'(rej_count), 0);
    rst = 1'b1;
    @(negedge clk);
    // in_valid in IDLE must not be consumed
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hAA;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("idle_in_ready", 32'(bus.in_ready), 0);
    chk("idle_busy", 32'(busy), 0);

    // Run 1
    pulse_start();
    put_byte(8'hD2); put_byte(8'h04); put_byte(8'h00);
    eval_triple(0);
    put_byte(8'h01); put_byte(8'hE0); put_byte(8'h7F);
    eval_triple(0);
    put_byte(8'h00); put_byte(8'hE0); put_byte(8'hFF);
    eval_triple(5);
    // start mid-triple is ignored; the triple still completes
    begin
      int c;
      c = rand_acc();
      put_byte(8'(c & 255));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_start_busy", 32'(busy), 1);
      chk("ign_start_rej", 32'(rej_count), 32'(exp_rej));
      put_byte(8'((c >> 8) & 255));
      put_byte(8'((c >> 16) & 127));
      eval_triple(1);
    end
    send(rand_rej(), 0);
    send(rand_acc(), 2);
    // DONE: value retained, bytes not consumed
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h55;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("done_hold", 32'(done), 1);
    chk("done_in_ready", 32'(bus.in_ready), 0);
    chk("done_out_coeff", bus.out_coeff, 32'(exp_coeff));

    // Run 2: rejection counter saturates
    pulse_start();
    for (int i = 0; i < SATV + 2; i++) send(rand_rej(), 0);
    chk("sat_rej", 32'(rej_count), 32'(SATV));

    // Asynchronous reset in the middle of a triple
    put_byte(8'h77); put_byte(8'h66);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_out_coeff", bus.out_coeff, 0);
    chk("arst_in_ready", 32'(bus.in_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rej", 32'(rej_count), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Run 3: stale partial bytes must not leak into the first triple
    pulse_start();
    put_byte(8'h05); put_byte(8'h00); put_byte(8'h00);
    eval_triple(0);
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 1) == 1) send(rand_rej(), 0);
      send(rand_acc(), int'($urandom_range(0, 3)));
    end
    chk("run3_done", 32'(done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coeff_byte_assembler.md
Name: coeff_byte_assembler

Overview:
- Upstream feeder for the Decompose stage.
- Collects a user/byte stream three bytes at a time and forms little-endian 23-bit candidates.
- Rejects candidates >= Q, using the Dilithium RejNTTPoly rule.
- Emits accepted coefficients as 32-bit `r` values on a valid/ready handshake until N coefficients have been produced. The output drives Decompose's `r` input directly.

Parameters:
- WIDTH, 32, width of out_coeff; matches the Decompose `r` width.
- Q, 8380417, modulus; candidates >= Q are rejected.
- N, 256, number of accepted coefficients per run.
- CNT_W, 16, width of rej_count.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- start  input  1  one-cycle pulse; begins a run
- in_byte  input  8  byte stream data
- in_valid  input  1  in_byte valid
- in_ready  output  1  block accepts a byte this cycle
- out_coeff  output  WIDTH  accepted coefficient, zero-extended
- out_valid  output  1  out_coeff valid
- out_ready  input  1  downstream accepts out_coeff
- busy  output  1  run in progress (COLLECT or EMIT)
- done  output  1  N coefficients delivered; held until next start
- rej_count  output  CNT_W  candidates rejected this run; saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. byte_idx=0, coeff_idx=0, byte regs=0. Outputs: out_coeff=0, out_valid=0, in_ready=0, busy=0, done=0, rej_count=0. A partial triple is discarded.
- FSM states: IDLE, COLLECT, EMIT, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> clear byte_idx, coeff_idx and rej_count; go to COLLECT next cycle.
- COLLECT:
  - in_ready=1, busy=1.
  - Byte handshake = in_valid & in_ready. Each handshake stores in_byte at byte_idx (0=LSB) and increments byte_idx.
  - On the handshake with byte_idx==2:
    - candidate = {in_byte[6:0], b1, b0}; bit 7 of byte 2 is masked, giving 23 bits.
    - byte_idx returns to 0.
    - If candidate < Q: register out_coeff = zero-extended candidate; go to EMIT; out_valid=1 on the next cycle (1-cycle latency).
    - Else: rej_count += 1 (saturates at 2^CNT_W-1); stay in COLLECT; out_valid stays 0.
- EMIT:
  - out_valid=1, in_ready=0, busy=1.
  - out_coeff must hold stable while out_ready=0.
  - out_valid & out_ready:
    - If coeff_idx==N-1: go to DONE.
    - Else: coeff_idx+1; go to COLLECT.
  - out_valid deasserts the cycle after the handshake.
- DONE:
  - done=1, busy=0, in_ready=0.
  - out_coeff retains the last accepted value.
  - start -> clear done and counters; go to COLLECT (same as the IDLE start).
- start during COLLECT or EMIT is ignored.
- in_valid is ignored whenever in_ready=0; no byte is consumed.
- Throughput is at most 1 coefficient per 4 cycles (3 byte cycles + 1 emit cycle); there are no bubbles beyond this.
- Comparison: a 23-bit unsigned compare against Q, done combinationally in the third-byte cycle and registered with out_coeff.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready. All outputs are registered or decoded from the state register.

Decomposition:
- Shared package dilithium_pkg holds:
  - constants Q=8380417, N=256, GAMMA2=(Q-1)/32 (shared with Decompose);
  - typedef coeff_t = logic [31:0];
  - enum asm_state_t {IDLE, COLLECT, EMIT, DONE}.
- No sub-module; the block is a single FSM plus datapath.
- For board bring-up, a top wrapper instantiates coeff_byte_assembler -> Decompose, in place of a constant `r`.

Test Plan:
- 1234 path: reset, start, bytes 0xD2,0x04,0x00 -> out_valid=1 one cycle after the third byte, out_coeff=1234, rej_count=0. Feeding Decompose gives r1=0, r0=1234.
- Rejection at Q: bytes 0x01,0xE0,0x7F (0x7FE001=Q) -> no out_valid, rej_count=1.
  - Follow with bytes 0x00,0xE0,0xFF -> bit 7 masked to 0x7FE000=8380416, accepted, out_coeff=8380416.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid stays 1, out_coeff unchanged, in_ready=0, extra in_valid bytes not consumed. Raising out_ready completes the handshake and returns to COLLECT.
- Run completion (N=4): feed 4 valid triples, one invalid interleaved -> done=1 after the 4th output handshake, busy=0, rej_count=1, in_ready=0. A new start clears done and rej_count.
- Reset mid-collect: after 2 bytes, pulse rst=0 -> all outputs 0 immediately (asynchronous). After rst=1 and start, bytes 0x05,0x00,0x00 -> out_coeff=5; the stale partial bytes are not used.
- Ignored start: pulse start after 1 byte in COLLECT -> byte_idx, coeff_idx and rej_count unchanged. The next 2 bytes complete the same triple.
